seq_alu_core: RTL
=================

// Module: seq_alu_core
// PURPOSE
//  Parametrised multi-cycle ALU: WIDTH-bit successor to the 1-bit add/sub/shift/pass slice.
//  Accepts one operation through a valid/ready input handshake, computes iteratively and holds
//  the result and flags until a valid/ready output handshake; sits between operand fetch and writeback.
//  Shift-left runs one bit per cycle; the optional multiply is shift-add, one bit per cycle.
// PARAMETERS
//  WIDTH    64                 operand/result width in bits (>=2)
//  SHAMT_W  $clog2(WIDTH)      width of the shift-amount port
// PORTS
//  clk        in   1        single clock, rising edge
//  reset      in   1        asynchronous, active-high; returns block to IDLE
//  in_valid   in   1        operation request valid
//  in_ready   out  1        block can accept a request (high only in IDLE)
//  ctrl       in   3        000 PASS_B, 001 SHL_A, 010 ADD, 011 SUB, 100 MUL (macro), others illegal
//  a          in   WIDTH    operand A
//  b          in   WIDTH    operand B
//  shamt      in   SHAMT_W  SHL_A shift amount
//  out_valid  out  1        result and flags valid, held until accepted
//  out_ready  in   1        consumer accepts result
//  result     out  WIDTH    operation result
//  flag_n     out  1        negative: result[WIDTH-1]
//  flag_z     out  1        zero: result == 0
//  flag_c     out  1        carry (see BEHAVIOUR)
//  flag_v     out  1        signed overflow
//  illegal    out  1        request had an unsupported ctrl code
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=1; out_valid=0; result, flags, illegal = 0. Reset mid-operation
//   aborts the operation; no result is produced.
//  FSM: IDLE -(in_valid)-> BUSY -(count done)-> DONE -(out_ready)-> IDLE.
//   Accept = in_valid & in_ready. a, b, ctrl and shamt are captured on accept; later changes are ignored.
//   in_ready=0 in BUSY and DONE. A request is never accepted in the same cycle as an output handshake.
//  Latency, from the accept edge to the out_valid rising edge:
//   PASS_B/ADD/SUB/illegal: 1 cycle. SHL_A: max(shamt,1) cycles. MUL: WIDTH cycles.
//  DONE: out_valid=1. result, flags and illegal are stable until the out_ready edge;
//   out_valid then drops on the next cycle.
//  Outputs are not updated while BUSY; the previous values are held.
//  Arithmetic, modulo 2^WIDTH:
//   ADD:  result=a+b; c=carry-out; v=(a[MSB]==b[MSB]) & (result[MSB]!=a[MSB]).
//   SUB:  result=a+~b+1; c=carry-out (1 = no borrow, a>=b unsigned); v=(a[MSB]!=b[MSB]) & (result[MSB]!=a[MSB]).
//   SHL_A: shift left one bit per cycle; c=last bit shifted out (0 if shamt==0); v=0.
//   PASS_B: result=b; c=0; v=0.
//  illegal: result=0, z=1, n=c=v=0, illegal=1. illegal=0 for every supported op.
// CONFIGURATION
//  SEQ_ALU_MUL_EN defined: ctrl 100 = unsigned MUL via shift-add, WIDTH iterations.
//   result=low WIDTH bits of a*b; c=1 if the high WIDTH bits are nonzero; v=0.
//  SEQ_ALU_MUL_EN undefined: no multiplier hardware; ctrl 100 is illegal, handled as above.
// TESTING (bench at WIDTH=8 and WIDTH=64)
//  1. reset asserted mid-BUSY (SHL shamt=5, reset at cycle 2) -> in_ready=1 and out_valid=0
//     asynchronously; no out_valid follows.
//  2. W=8 ADD a=0x7F b=0x01 -> out_valid 1 cycle after accept, result=0x80, n=1 z=0 c=0 v=1;
//     ADD 0xFF+0x01 -> result=0x00, z=1 c=1 v=0.
//  3. W=8 SUB a=0x05 b=0x07 -> result=0xFE, n=1 c=0 v=0; SUB 0x80-0x01 -> result=0x7F, c=1 v=1.
//  4. W=8 SHL a=0x81 shamt=1 -> 1 cycle, result=0x02 c=1; shamt=7 -> 7 cycles, result=0x80 c=0;
//     shamt=0 -> 1 cycle, result=0x81 c=0.
//  5. Backpressure: hold out_ready=0 for 10 cycles after done -> result stable, in_ready=0,
//     a second in_valid is not accepted; raise out_ready -> IDLE next cycle, second request accepted.
//  6. ctrl=100 a=0x10 b=0x11 -> with macro: 8 cycles, result=0x10 c=1;
//     without macro: 1 cycle, illegal=1 result=0 z=1. ctrl=111 -> illegal=1 in both builds.

Source files
------------

// File: rtl/seq_alu_core_if.sv
// rtl/seq_alu_core_if.sv - request/response bundle for seq_alu_core
//
// Groups the input handshake (in_valid/in_ready plus ctrl, a, b, shamt) and the
// output handshake (out_valid/out_ready plus result, flags, illegal).
// master: operand-fetch / consumer side. slave: the ALU.
interface seq_alu_core_if #(
    parameter int WIDTH   = 64,
    parameter int SHAMT_W = $clog2(WIDTH)
);
    logic               in_valid;
    logic               in_ready;
    logic [2:0]         ctrl;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [SHAMT_W-1:0] shamt;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   result;
    logic               flag_n;
    logic               flag_z;
    logic               flag_c;
    logic               flag_v;
    logic               illegal;

    modport master (
        output in_valid, ctrl, a, b, shamt, out_ready,
        input  in_ready, out_valid, result, flag_n, flag_z, flag_c, flag_v, illegal
    );

    modport slave (
        input  in_valid, ctrl, a, b, shamt, out_ready,
        output in_ready, out_valid, result, flag_n, flag_z, flag_c, flag_v, illegal
    );
endinterface

// File: rtl/seq_alu_core.sv
// rtl/seq_alu_core.sv - multi-cycle WIDTH-bit ALU (pass/shl/add/sub, optional mul)
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high; aborts any operation in flight
//   bus    seq_alu_core_if.slave: request handshake with ctrl/a/b/shamt,
//          response handshake with result/flag_n/flag_z/flag_c/flag_v/illegal
// ctrl: 000 PASS_B, 001 SHL_A, 010 ADD, 011 SUB, 100 MUL, others illegal.
// Build option: define SEQ_ALU_MUL_EN to add the shift-add multiplier; without
// it ctrl 100 is reported as illegal.
module seq_alu_core #(
    parameter int WIDTH   = 64,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input logic           clk,
    input logic           reset,
    seq_alu_core_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_BUSY = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_SHL  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_MUL  = 3'b100;

    localparam int MSB = WIDTH - 1;

    logic [1:0]         state;
    logic [2:0]         op_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [SHAMT_W-1:0] cnt;

    logic [WIDTH-1:0]   result_r;
    logic               flag_n_r, flag_z_r, flag_c_r, flag_v_r, illegal_r;

    logic               fin;
    logic [WIDTH-1:0]   fin_res;
    logic               fin_c, fin_v, fin_ill;
    logic [WIDTH-1:0]   nxt_a;
    logic [WIDTH:0]     add_full, sub_full;

`ifdef SEQ_ALU_MUL_EN
    // Product accumulates as {hi_r, b_r}: the multiplier is consumed from b_r's
    // LSB while product bits shift in from the top.
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   nxt_hi;
    logic [WIDTH-1:0]   nxt_b;
    logic [WIDTH:0]     mul_sum;
`endif

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.out_valid = (state == S_DONE);
    assign bus.result    = result_r;
    assign bus.flag_n    = flag_n_r;
    assign bus.flag_z    = flag_z_r;
    assign bus.flag_c    = flag_c_r;
    assign bus.flag_v    = flag_v_r;
    assign bus.illegal   = illegal_r;

    // One BUSY step: decide whether this edge finishes and what it writes.
    always_comb begin
        fin      = 1'b0;
        fin_res  = '0;
        fin_c    = 1'b0;
        fin_v    = 1'b0;
        fin_ill  = 1'b0;
        nxt_a    = a_r;
        add_full = {1'b0, a_r} + {1'b0, b_r};
        // Subtract as a + ~b + 1 so the carry-out reads as "no borrow".
        sub_full = {1'b0, a_r} + {1'b0, ~b_r} + {{WIDTH{1'b0}}, 1'b1};
`ifdef SEQ_ALU_MUL_EN
        mul_sum  = {1'b0, hi_r} + (b_r[0] ? {1'b0, a_r} : {(WIDTH+1){1'b0}});
        nxt_hi   = mul_sum[WIDTH:1];
        nxt_b    = {mul_sum[0], b_r[WIDTH-1:1]};
`endif
        case (op_r)
            OP_PASS: begin
                fin     = 1'b1;
                fin_res = b_r;
            end
            OP_ADD: begin
                fin     = 1'b1;
                fin_res = add_full[WIDTH-1:0];
                fin_c   = add_full[WIDTH];
                fin_v   = (a_r[MSB] == b_r[MSB]) && (add_full[MSB] != a_r[MSB]);
            end
            OP_SUB: begin
                fin     = 1'b1;
                fin_res = sub_full[WIDTH-1:0];
                fin_c   = sub_full[WIDTH];
                fin_v   = (a_r[MSB] != b_r[MSB]) && (sub_full[MSB] != a_r[MSB]);
            end
            OP_SHL: begin
                // cnt==0 only happens for shamt==0: pass a through in one cycle.
                if (cnt == '0) begin
                    fin     = 1'b1;
                    fin_res = a_r;
                end else begin
                    nxt_a   = {a_r[WIDTH-2:0], 1'b0};
                    fin     = (cnt == SHAMT_W'(1));
                    fin_res = nxt_a;
                    fin_c   = a_r[MSB];
                end
            end
`ifdef SEQ_ALU_MUL_EN
            OP_MUL: begin
                fin     = (cnt == '0);
                fin_res = nxt_b;
                fin_c   = |nxt_hi;
            end
`endif
            default: begin
                fin     = 1'b1;
                fin_ill = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            op_r      <= '0;
            a_r       <= '0;
            b_r       <= '0;
            cnt       <= '0;
            result_r  <= '0;
            flag_n_r  <= 1'b0;
            flag_z_r  <= 1'b0;
            flag_c_r  <= 1'b0;
            flag_v_r  <= 1'b0;
            illegal_r <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
            hi_r      <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        state <= S_BUSY;
                        op_r  <= bus.ctrl;
                        a_r   <= bus.a;
                        b_r   <= bus.b;
`ifdef SEQ_ALU_MUL_EN
                        hi_r  <= '0;
                        cnt   <= (bus.ctrl == OP_MUL) ? SHAMT_W'(WIDTH - 1) : bus.shamt;
`else
                        cnt   <= bus.shamt;
`endif
                    end
                end
                S_BUSY: begin
                    a_r <= nxt_a;
`ifdef SEQ_ALU_MUL_EN
                    b_r  <= nxt_b;
                    hi_r <= nxt_hi;
`endif
                    if (fin) begin
                        state     <= S_DONE;
                        result_r  <= fin_res;
                        flag_n_r  <= fin_res[MSB];
                        flag_z_r  <= (fin_res == '0);
                        flag_c_r  <= fin_c;
                        flag_v_r  <= fin_v;
                        illegal_r <= fin_ill;
                    end else begin
                        cnt <= cnt - SHAMT_W'(1);
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
